// File: rtl/wb_simple_master_pkg.sv
// Shared types and helpers for the single-beat Wishbone B4 master front-end.
package wb_simple_master_pkg;

  // Default bus widths used by the master and its users.
  localparam int WB_ADDR_WIDTH = 32;
  localparam int WB_DATA_WIDTH = 32;

  // Bus handshake flavour: classic holds stb until termination, pipelined
  // drops stb as soon as the slave accepts the request (stall low).
  typedef enum logic {
    CLASSIC   = 1'b0,
    PIPELINED = 1'b1
  } t_wishbone_interface_mode;

  // Address unit on the bus side: BYTE passes the byte address through,
  // WORD divides it by the number of byte lanes.
  typedef enum logic {
    BYTE = 1'b0,
    WORD = 1'b1
  } t_wishbone_address_granularity;

  // Result reported to the requester with every response strobe.
  typedef enum logic [1:0] {
    WB_OK      = 2'd0,
    WB_ERR     = 2'd1,
    WB_RTY     = 2'd2,
    WB_TIMEOUT = 2'd3
  } t_wb_status;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } t_wb_state;

  // Resolve simultaneous terminations: err beats rty, rty beats ack.
  function automatic t_wb_status wb_term_status(input logic err, input logic rty);
    t_wb_status st;
    if (err) begin
      st = WB_ERR;
    end else if (rty) begin
      st = WB_RTY;
    end else begin
      st = WB_OK;
    end
    return st;
  endfunction

  // Width of the timeout counter; never narrower than one bit so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int wb_cnt_width(input int timeout);
    int w;
    if (timeout > 0) begin
      w = $clog2(timeout + 1);
    end else begin
      w = 1;
    end
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/wb_simple_master.sv
// Single-beat Wishbone B4 master: accepts one valid/ready request, runs one
// bus transaction (classic or pipelined) and returns a one-cycle response
// carrying OK/ERR/RTY/TIMEOUT and, for OK reads, the read data.
module wb_simple_master
  import wb_simple_master_pkg::*;
#(
  parameter int                            ADDR_WIDTH  = WB_ADDR_WIDTH,
  parameter int                            DATA_WIDTH  = WB_DATA_WIDTH,
  parameter t_wishbone_interface_mode      MODE        = PIPELINED,
  parameter t_wishbone_address_granularity GRANULARITY = BYTE,
  parameter int                            TIMEOUT     = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  // request side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_adr,
  input  logic [DATA_WIDTH/8-1:0] req_sel,
  input  logic [DATA_WIDTH-1:0]   req_dat,
  // response side
  output logic                    rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [DATA_WIDTH-1:0]   rsp_dat,
  // Wishbone master side
  output logic                    wb_cyc,
  output logic                    wb_stb,
  output logic [ADDR_WIDTH-1:0]   wb_adr,
  output logic [DATA_WIDTH/8-1:0] wb_sel,
  output logic                    wb_we,
  output logic [DATA_WIDTH-1:0]   wb_dato,
  input  logic                    wb_ack,
  input  logic                    wb_err,
  input  logic                    wb_rty,
  input  logic                    wb_stall,
  input  logic [DATA_WIDTH-1:0]   wb_dati
);

  localparam int SEL_W     = DATA_WIDTH / 8;
  localparam int CNT_W     = wb_cnt_width(TIMEOUT);
  localparam int ADR_SHIFT = (GRANULARITY == WORD) ? $clog2(SEL_W) : 0;
  // Counter value at which an unterminated transaction is aborted.
  localparam logic [CNT_W-1:0] TO_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : {CNT_W{1'b0}};

  // Sequencer state and timeout counter
  t_wb_state        state_r;
  t_wb_state        state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;

  // Registered outputs and their next values
  logic                  req_ready_r, req_ready_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic [1:0]            rsp_status_r, rsp_status_s;
  logic [DATA_WIDTH-1:0] rsp_dat_r, rsp_dat_s;
  logic                  wb_cyc_r, wb_cyc_s;
  logic                  wb_stb_r, wb_stb_s;
  logic [ADDR_WIDTH-1:0] wb_adr_r, wb_adr_s;
  logic [SEL_W-1:0]      wb_sel_r, wb_sel_s;
  logic                  wb_we_r, wb_we_s;
  logic [DATA_WIDTH-1:0] wb_dato_r, wb_dato_s;

  // Per-cycle decode of bus events
  logic                  busy_s;
  logic                  term_s;
  logic                  timeout_s;
  logic                  finish_s;
  logic                  accepted_s;
  t_wb_status            result_s;
  logic [DATA_WIDTH-1:0] result_dat_s;
  logic [ADDR_WIDTH-1:0] mapped_adr_s;

  // Terminations only count while a cycle is open; outside STROBE/WAIT they
  // are ignored. A termination on the abort edge wins over the timeout.
  assign busy_s       = (state_r == ST_STROBE) || (state_r == ST_WAIT);
  assign term_s       = busy_s && (wb_ack || wb_err || wb_rty);
  assign timeout_s    = busy_s && (TIMEOUT != 0) && (cnt_r == TO_LAST) && !term_s;
  assign finish_s     = term_s || timeout_s;
  assign accepted_s   = (MODE == PIPELINED) && !wb_stall;
  assign result_s     = timeout_s ? WB_TIMEOUT : wb_term_status(wb_err, wb_rty);
  assign result_dat_s = ((result_s == WB_OK) && !wb_we_r) ? wb_dati : {DATA_WIDTH{1'b0}};
  assign mapped_adr_s = req_adr >> ADR_SHIFT;

  // State, timeout counter and every output register advance on the clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_status_r <= 2'd0;
      rsp_dat_r    <= {DATA_WIDTH{1'b0}};
      wb_cyc_r     <= 1'b0;
      wb_stb_r     <= 1'b0;
      wb_adr_r     <= {ADDR_WIDTH{1'b0}};
      wb_sel_r     <= {SEL_W{1'b0}};
      wb_we_r      <= 1'b0;
      wb_dato_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= req_ready_s;
      rsp_valid_r  <= rsp_valid_s;
      rsp_status_r <= rsp_status_s;
      rsp_dat_r    <= rsp_dat_s;
      wb_cyc_r     <= wb_cyc_s;
      wb_stb_r     <= wb_stb_s;
      wb_adr_r     <= wb_adr_s;
      wb_sel_r     <= wb_sel_s;
      wb_we_r      <= wb_we_s;
      wb_dato_r    <= wb_dato_s;
    end
  end

  // Next-state and timeout-counter selection.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (req_valid) begin
          state_s = ST_STROBE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STROBE: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (finish_s) begin
          state_s = ST_RESP;
        end else if (accepted_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_STROBE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (finish_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs for the current state and events.
  always_comb begin
    req_ready_s  = req_ready_r;
    rsp_valid_s  = 1'b0;
    rsp_status_s = rsp_status_r;
    rsp_dat_s    = rsp_dat_r;
    wb_cyc_s     = wb_cyc_r;
    wb_stb_s     = wb_stb_r;
    wb_adr_s     = wb_adr_r;
    wb_sel_s     = wb_sel_r;
    wb_we_s      = wb_we_r;
    wb_dato_s    = wb_dato_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          req_ready_s = 1'b0;
          wb_cyc_s    = 1'b1;
          wb_stb_s    = 1'b1;
          wb_adr_s    = mapped_adr_s;
          wb_sel_s    = req_sel;
          wb_we_s     = req_we;
          wb_dato_s   = req_dat;
        end else begin
          req_ready_s = 1'b1;
          wb_cyc_s    = 1'b0;
          wb_stb_s    = 1'b0;
        end
      end
      ST_STROBE, ST_WAIT: begin
        req_ready_s = 1'b0;
        if (finish_s) begin
          wb_cyc_s     = 1'b0;
          wb_stb_s     = 1'b0;
          rsp_valid_s  = 1'b1;
          rsp_status_s = result_s;
          rsp_dat_s    = result_dat_s;
        end else if ((state_r == ST_STROBE) && accepted_s) begin
          wb_stb_s = 1'b0;
        end else begin
          wb_stb_s = wb_stb_r;
        end
      end
      ST_RESP: begin
        req_ready_s = 1'b1;
        wb_cyc_s    = 1'b0;
        wb_stb_s    = 1'b0;
      end
      default: begin
        req_ready_s = 1'b1;
        wb_cyc_s    = 1'b0;
        wb_stb_s    = 1'b0;
      end
    endcase
  end

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_status = rsp_status_r;
  assign rsp_dat    = rsp_dat_r;
  assign wb_cyc     = wb_cyc_r;
  assign wb_stb     = wb_stb_r;
  assign wb_adr     = wb_adr_r;
  assign wb_sel     = wb_sel_r;
  assign wb_we      = wb_we_r;
  assign wb_dato    = wb_dato_r;

endmodule

// File: tb/tb_wb_simple_master.sv
// Bench for wb_simple_master: instance A is pipelined/byte with an 8-cycle
// timeout, instance B is classic/word with the timeout disabled.
module tb_wb_simple_master;
  import wb_simple_master_pkg::*;

  localparam int TO_A = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = 32'h0, req_dat = 32'h0, wb_dati = 32'h0;
  logic [3:0]  req_sel = 4'h0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;

  logic        rdy_a, rv_a, cyc_a, stb_a, we_a, rdy_b, rv_b, cyc_b, stb_b, we_b;
  logic [1:0]  st_a, st_b;
  logic [31:0] rd_a, adr_a, dato_a, rd_b, adr_b, dato_b;
  logic [3:0]  sel_a, sel_b;

  wb_simple_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MODE(PIPELINED),
                     .GRANULARITY(BYTE), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(rdy_a), .req_we(req_we),
    .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat), .rsp_valid(rv_a),
    .rsp_status(st_a), .rsp_dat(rd_a), .wb_cyc(cyc_a), .wb_stb(stb_a), .wb_adr(adr_a),
    .wb_sel(sel_a), .wb_we(we_a), .wb_dato(dato_a), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_rty(wb_rty), .wb_stall(wb_stall), .wb_dati(wb_dati));

  wb_simple_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MODE(CLASSIC),
                     .GRANULARITY(WORD), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(rdy_b), .req_we(req_we),
    .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat), .rsp_valid(rv_b),
    .rsp_status(st_b), .rsp_dat(rd_b), .wb_cyc(cyc_b), .wb_stb(stb_b), .wb_adr(adr_b),
    .wb_sel(sel_b), .wb_we(we_b), .wb_dato(dato_b), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_rty(wb_rty), .wb_stall(wb_stall), .wb_dati(wb_dati));

  // View of whichever instance the current step exercises
  bit          cur_b = 1'b0;
  logic        m_rdy, m_rv, m_cyc, m_stb, m_we;
  logic [1:0]  m_st;
  logic [31:0] m_rd, m_adr, m_dato;
  logic [3:0]  m_sel;
  assign m_rdy  = cur_b ? rdy_b  : rdy_a;
  assign m_rv   = cur_b ? rv_b   : rv_a;
  assign m_cyc  = cur_b ? cyc_b  : cyc_a;
  assign m_stb  = cur_b ? stb_b  : stb_a;
  assign m_we   = cur_b ? we_b   : we_a;
  assign m_st   = cur_b ? st_b   : st_a;
  assign m_rd   = cur_b ? rd_b   : rd_a;
  assign m_adr  = cur_b ? adr_b  : adr_a;
  assign m_dato = cur_b ? dato_b : dato_a;
  assign m_sel  = cur_b ? sel_b  : sel_a;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_valid(input bit v);
    if (cur_b) req_valid_b = v; else req_valid_a = v;
  endtask

  // One transaction. The slave stalls for the first s edges after cyc rises,
  // then terminates d edges after the edge that took the request
  // (term = {err,rty,ack}; 0 means it never answers). Expected outcome is
  // derived from the bus rules: err > rty > ack, abort at edge TO_A if
  // nothing arrived by then, pipelined stb lasts until the stall drops.
  task automatic run_txn(input bit use_b, input bit we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, input int s,
                         input int d, input logic [2:0] term, input logic [31:0] dati,
                         input bit poke);
    int t, exp_edge, exp_stb, stb_cnt, to_lim;
    logic [1:0]  exp_st;
    logic [31:0] exp_dat, exp_adr;
    bit got;
    cur_b  = use_b;
    t      = s + 1 + d;
    to_lim = use_b ? 0 : TO_A;
    if (term != 3'b000 && (to_lim == 0 || t <= to_lim)) begin
      exp_edge = t;
      exp_st   = term[2] ? 2'd1 : (term[1] ? 2'd2 : 2'd0);
    end else begin
      exp_edge = to_lim;
      exp_st   = 2'd3;
    end
    exp_stb = use_b ? exp_edge : ((s + 1 < exp_edge) ? s + 1 : exp_edge);
    exp_dat = (exp_st == 2'd0 && !we) ? dati : 32'h0;
    exp_adr = use_b ? (adr >> 2) : adr;

    @(negedge clk);
    req_we = we; req_adr = adr; req_sel = sel; req_dat = dat;
    set_valid(1'b1);
    @(posedge clk); #1;
    set_valid(1'b0);
    check("start_cyc", m_cyc, 1'b1);
    check("start_stb", m_stb, 1'b1);
    check("start_ready", m_rdy, 1'b0);
    check("wb_adr", m_adr, exp_adr);
    check("wb_sel", m_sel, sel);
    check("wb_we", m_we, we);
    check("wb_dato", m_dato, dat);

    stb_cnt = 0;
    got     = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      wb_stall = (k <= s);
      wb_err   = term[2] && (k == t);
      wb_rty   = term[1] && (k == t);
      wb_ack   = term[0] && (k == t);
      wb_dati  = dati;
      if (poke && k == 1) begin
        req_adr = ~adr;
        set_valid(1'b1);
      end
      if (m_stb) stb_cnt++;
      @(posedge clk); #1;
      set_valid(1'b0);
      if (m_rv) begin
        got = 1'b1;
        check("rsp_edge", k, exp_edge);
        check("rsp_status", m_st, exp_st);
        check("rsp_dat", m_rd, exp_dat);
        check("rsp_cyc_low", m_cyc, 1'b0);
        check("rsp_stb_low", m_stb, 1'b0);
        check("rsp_ready_low", m_rdy, 1'b0);
      end
    end
    wb_stall = 1'b0; wb_err = 1'b0; wb_rty = 1'b0; wb_ack = 1'b0;
    check("rsp_seen", got, 1'b1);
    check("stb_cycles", stb_cnt, exp_stb);
    @(posedge clk); #1;
    check("post_rsp_valid", m_rv, 1'b0);
    check("post_ready", m_rdy, 1'b1);
    check("post_cyc", m_cyc, 1'b0);
  endtask

  initial begin
    bit quiet;
    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cur_b = (i == 1);
      #0;
      check("rst_ready", m_rdy, 1'b1);
      check("rst_cyc", m_cyc, 1'b0);
      check("rst_stb", m_stb, 1'b0);
      check("rst_we", m_we, 1'b0);
      check("rst_adr", m_adr, 32'h0);
      check("rst_sel", m_sel, 4'h0);
      check("rst_dato", m_dato, 32'h0);
      check("rst_rsp_valid", m_rv, 1'b0);
      check("rst_rsp_status", m_st, 2'd0);
      check("rst_rsp_dat", m_rd, 32'h0);
    end

    // Terminations with no open cycle are ignored
    cur_b = 1'b0;
    @(negedge clk);
    wb_ack = 1'b1; wb_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_term_rsp", m_rv, 1'b0);
    check("idle_term_cyc", m_cyc, 1'b0);
    wb_ack = 1'b0; wb_err = 1'b0;

    // Directed cases
    run_txn(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 3'b001, 32'hCAFE0000, 1'b0);
    run_txn(1'b0, 1'b0, 32'h20, 4'hF, 32'h0, 3, 2, 3'b001, 32'h12345678, 1'b1);
    run_txn(1'b1, 1'b0, 32'h40, 4'h3, 32'h0, 2, 1, 3'b001, 32'hA5A5F00D, 1'b0);
    run_txn(1'b0, 1'b0, 32'h44, 4'hF, 32'h0, 1, 0, 3'b101, 32'h11112222, 1'b0);
    run_txn(1'b0, 1'b0, 32'h48, 4'hF, 32'h0, 0, 1, 3'b010, 32'h33334444, 1'b0);
    run_txn(1'b0, 1'b0, 32'h4C, 4'hF, 32'h0, 0, 0, 3'b000, 32'h55556666, 1'b0);
    run_txn(1'b0, 1'b0, 32'h50, 4'hF, 32'h0, 2, 5, 3'b001, 32'h77778888, 1'b0);

    // Disabled timeout: no abort within 1000 cycles, then a normal ack
    cur_b = 1'b1;
    @(negedge clk);
    req_we = 1'b0; req_adr = 32'h100; req_sel = 4'hF;
    req_valid_b = 1'b1;
    @(posedge clk); #1;
    req_valid_b = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (m_rv || !m_cyc) quiet = 1'b0;
    end
    check("no_timeout_quiet", quiet, 1'b1);
    wb_ack = 1'b1; wb_dati = 32'h0BADF00D;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    check("no_timeout_rsp", m_rv, 1'b1);
    check("no_timeout_status", m_st, 2'd0);
    check("no_timeout_dat", m_rd, 32'h0BADF00D);
    @(posedge clk); #1;

    // Reset two cycles into a stalled transaction
    cur_b = 1'b0;
    @(negedge clk);
    req_adr = 32'h200; wb_stall = 1'b1;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wb_stall = 1'b0;
    check("mid_rst_cyc", m_cyc, 1'b0);
    check("mid_rst_stb", m_stb, 1'b0);
    check("mid_rst_rsp", m_rv, 1'b0);
    check("mid_rst_ready", m_rdy, 1'b1);
    @(posedge clk); #1;
    check("mid_rst_rsp_later", m_rv, 1'b0);
    run_txn(1'b0, 1'b0, 32'h204, 4'hC, 32'h0, 1, 1, 3'b001, 32'h600DCAFE, 1'b0);

    // Randomized traffic on both instances
    for (int n = 0; n < 30; n++) begin
      bit          ub;
      logic [2:0]  tm;
      ub = (n % 3 == 2);
      tm = 3'($urandom_range(7, ub ? 1 : 0));
      run_txn(ub, 1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)), $urandom,
              $urandom_range(4, 0), $urandom_range(5, 0), tm, $urandom,
              1'($urandom_range(1, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
